pipe_stage_elastic: RTL and testbench

- Parametrised, elastic pipeline stage register; generalises the fixed MEM/WB latch.
- Adds valid/ready handshake, a 2-entry skid buffer (full throughput, registered in_ready), synchronous flush, and bubble masking of control fields.
- Sits between any two pipeline stages (IF/ID through MEM/WB); data and control payloads are packed by the instantiating stage.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_stage_elastic.sv | 117 +++++++++++
 tb/tb_pipe_stage_elastic.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types for elastic pipeline stages: FSM encoding, standard MEM/WB
// payload widths and an occupancy helper.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } pipe_state_t;

    // MEM/WB data = {alu_result, mem_read_data, pc_plus4}; ctrl = {memtoreg[1:0], writereg[4:0], regwrite}
    localparam int MEMWB_DATA_W = 96;
    localparam int MEMWB_CTRL_W = 8;

    function automatic logic [1:0] occupancy_of(input pipe_state_t st);
        case (st)
            ST_ONE:  return 2'd1;
            ST_TWO:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: main slot drives the outputs, skid slot absorbs one
// extra entry so in_ready can be a flop without losing throughput.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                CTRL_W   = 8,
    parameter logic [CTRL_W-1:0] CTRL_RST = {CTRL_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    // Handshake: a transfer happens on a posedge where valid and ready are both 1;
    // valid never waits on ready, and a held entry stays stable until taken.

    pipe_state_t       state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [DATA_W-1:0] main_data_q, skid_data_q;
    logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;

    logic in_xfer, out_xfer;
    logic load_main_in, load_main_skid, load_skid;

    assign in_ready = in_ready_q;
    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_data_q <= '0;
            main_ctrl_q <= CTRL_RST;
            skid_data_q <= '0;
            skid_ctrl_q <= CTRL_RST;
        end else begin
            if (load_main_in) begin
                main_data_q <= in_data;
                main_ctrl_q <= in_ctrl;
            end else if (load_main_skid) begin
                main_data_q <= skid_data_q;
                main_ctrl_q <= skid_ctrl_q;
            end
            if (load_skid) begin
                skid_data_q <= in_data;
                skid_ctrl_q <= in_ctrl;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_d      = ST_ONE;
                    load_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    load_main_in = 1'b1;
                end else if (in_xfer) begin
                    state_d   = ST_TWO;
                    load_skid = 1'b1;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_xfer) begin
                    state_d        = ST_ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush squashes everything, including the entry arriving this cycle.
        if (flush) begin
            state_d        = ST_EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
        in_ready_d = (state_d != ST_TWO);
    end

    always_comb begin
        out_valid = (state_q == ST_ONE) || (state_q == ST_TWO);
        out_data  = main_data_q;
        out_ctrl  = out_valid ? main_ctrl_q : CTRL_RST;
        occupancy = occupancy_of(state_q);
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: directed scenarios then random traffic, with
// a queue of live entries as the reference model and a negedge monitor.
module tb_pipe_stage_elastic;

    localparam int DW = 32;
    localparam int CW = 8;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          flush     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic [CW-1:0] in_ctrl   = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [1:0]    occupancy;

    logic [DW+CW-1:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RST(8'h00)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // One cycle of stimulus; the model learns about accepted entries once
    // in_ready for this cycle is settled.
    task automatic drive(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input bit ordy, input bit fl, input bit rs);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        rst       = rs;
        @(negedge clk);
        #1;
        if (rs || fl) exp_q.delete();
        else if (v && in_ready) exp_q.push_back({c, d});
    endtask

    logic [DW+CW-1:0] prev_out;
    logic [DW+CW-1:0] exp_item;
    bit               prev_stall = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            check("occupancy", 64'(occupancy), 64'(exp_q.size()));
            check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            check("in_ready", 64'(in_ready), 64'(exp_q.size() != 2));
            if (!out_valid) check("bubble_ctrl", 64'(out_ctrl), 64'h0);
            if (prev_stall && out_valid) check("stall_hold", 64'({out_ctrl, out_data}), 64'(prev_out));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'({out_ctrl, out_data}), 64'h0);
                end else begin
                    exp_item = exp_q.pop_front();
                    check("fifo_order", 64'({out_ctrl, out_data}), 64'(exp_item));
                end
            end
            prev_stall = out_valid && !out_ready && !flush && !rst;
            prev_out   = {out_ctrl, out_data};
        end
    end

    initial begin
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Reset held with a live-looking input
        drive(1, 32'hFFFF_FFFF, 8'hFF, 0, 0, 1);
        drive(1, 32'hFFFF_FFFF, 8'hFF, 0, 0, 1);
        drive(1, 32'h1234_5678, 8'h3C, 1, 0, 0);
        check("reset_out_data", 64'(out_data), 64'h0);
        check("reset_out_ctrl", 64'(out_ctrl), 64'h0);
        drive(0, 32'h0, 8'h00, 1, 0, 0);
        check("first_latency", 64'(out_data), 64'h1234_5678);

        // Back-to-back streaming
        for (int i = 0; i < 4; i++) drive(1, 32'h10 + i, 8'(i + 1), 1, 0, 0);
        drive(0, 32'h0, 8'h00, 1, 0, 0);
        drive(0, 32'h0, 8'h00, 1, 0, 0);

        // Skid fill then drain
        drive(1, 32'hA0, 8'h11, 0, 0, 0);
        drive(1, 32'hA1, 8'h22, 0, 0, 0);
        drive(0, 32'h0, 8'h00, 0, 0, 0);
        check("skid_head", 64'(out_data), 64'hA0);
        for (int i = 0; i < 3; i++) drive(0, 32'h0, 8'h00, 1, 0, 0);

        // Flush from full with an incoming entry
        drive(1, 32'hB0, 8'h33, 0, 0, 0);
        drive(1, 32'hB1, 8'h44, 0, 0, 0);
        drive(1, 32'hB2, 8'h55, 0, 1, 0);
        for (int i = 0; i < 3; i++) drive(0, 32'h0, 8'h00, 1, 0, 0);

        // Control masked once the last entry drains
        drive(1, 32'hC0, 8'h5A, 0, 0, 0);
        drive(0, 32'h0, 8'h00, 1, 0, 0);
        check("bubble_live", 64'(out_ctrl), 64'h5A);
        drive(0, 32'h0, 8'h00, 1, 0, 0);
        check("bubble_mask", 64'(out_ctrl), 64'h0);

        // Reset and flush together while holding one entry
        drive(1, 32'hD0, 8'h77, 0, 0, 0);
        drive(0, 32'h0, 8'h00, 0, 1, 1);
        drive(0, 32'h0, 8'h00, 0, 0, 0);
        check("rstflush_data", 64'(out_data), 64'h0);
        check("rstflush_ctrl", 64'(out_ctrl), 64'h0);

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, 8'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0,
                  $urandom_range(0, 199) == 0);
        end
        for (int i = 0; i < 4; i++) drive(0, 32'h0, 8'h00, 1, 0, 0);
        check("final_empty", 64'(exp_q.size()), 64'h0);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
